// File: rtl/cv32e40x_pkg.sv
// Shared types for the write-back stage with eXtension result buffer.
//   mpu_status_e   : LSU MPU response; anything but MPU_OK is a load/store exception
//   ex_wb_pipe_t   : EX/WB pipeline register fields consumed by WB
//   ctrl_fsm_t     : controller kill/halt requests for WB
//   xif_rb_entry_t : one buffered coprocessor result {valid, id, data, we, exc}
package cv32e40x_pkg;

  localparam int X_RESULT_DEPTH_MAX = 8;
  localparam int XIF_ID_W           = 4;
  localparam int XIF_DATA_W         = 32;

  typedef enum logic [1:0] {
    MPU_OK       = 2'd0,
    MPU_RE_FAULT = 2'd1,
    MPU_WR_FAULT = 2'd2
  } mpu_status_e;

  typedef struct packed {
    logic                instr_valid;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         rf_wdata;
    logic                lsu_en;
    logic                xif_en;
    logic [XIF_ID_W-1:0] xif_id;
  } ex_wb_pipe_t;

  typedef struct packed {
    logic kill_wb;
    logic halt_wb;
  } ctrl_fsm_t;

  typedef struct packed {
    logic                  valid;
    logic [XIF_ID_W-1:0]   id;
    logic [XIF_DATA_W-1:0] data;
    logic                  we;
    logic                  exc;
  } xif_rb_entry_t;

endpackage

// File: rtl/cv32e40x_wb_stage_rb_if.sv
// eXtension interface result channel (coprocessor -> core).
//   master : coprocessor side, drives valid/id/data/we/exc, receives ready
//   slave  : core side, receives the result, drives ready
interface cv32e40x_wb_stage_rb_if #(
  parameter int X_ID_WIDTH   = 4,
  parameter int X_DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [X_ID_WIDTH-1:0]   id;
  logic [X_DATA_WIDTH-1:0] data;
  logic                    we;
  logic                    exc;

  modport master (output valid, id, data, we, exc, input ready);
  modport slave  (input valid, id, data, we, exc, output ready);
endinterface

// File: rtl/cv32e40x_xif_result_buffer.sv
// Coprocessor result buffer: DEPTH entries with ID CAM lookup against the WB
// instruction, same-cycle bypass, lowest-free allocation, free on retire/kill,
// flush, and a registered occupancy count.
//   clk, rst        : clock, synchronous active-high reset
//   flush_i         : drop every buffered result
//   lookup_en_i     : WB holds an offloaded instruction (unqualified valid)
//   lookup_id_i     : offload ID of the WB instruction
//   release_i       : WB instruction retires or is killed; drop its entry
//   res             : result channel (slave side)
//   hit_*_o         : matched result (buffered entry wins over incoming)
//   occupancy_o     : number of valid entries
module cv32e40x_xif_result_buffer
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  lookup_en_i,
  input  logic [XIF_ID_W-1:0]   lookup_id_i,
  input  logic                  release_i,
  cv32e40x_wb_stage_rb_if.slave res,
  output logic                  hit_o,
  output logic [XIF_DATA_W-1:0] hit_data_o,
  output logic                  hit_we_o,
  output logic                  hit_exc_o,
  output logic [OCC_W-1:0]      occupancy_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  xif_rb_entry_t    entry_q [DEPTH];
  logic [DEPTH-1:0] match_vec;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] alloc_idx;
  logic             any_free;
  logic             buf_hit;
  logic             id_match;
  logic             bypass;
  logic             alloc;
  logic             release_en;
  logic [OCC_W-1:0] occupancy_q;
  logic [OCC_W-1:0] occupancy_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_vec[gi] = entry_q[gi].valid && (entry_q[gi].id == lookup_id_i);
  end

  // Descending scan so the lowest index wins for both the hit and the free slot.
  always_comb begin
    hit_idx   = '0;
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) hit_idx = IDX_W'(i);
      if (!entry_q[i].valid) begin
        alloc_idx = IDX_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  assign buf_hit    = lookup_en_i && |match_vec;
  assign id_match   = lookup_en_i && (res.id == lookup_id_i);
  // A result for the WB instruction is always takeable, even with a full buffer.
  assign res.ready  = !rst && (any_free || id_match);
  assign bypass     = res.valid && res.ready && id_match && !buf_hit;
  // Free slots are judged on pre-cycle valids, so a slot released now is not reused.
  assign alloc      = res.valid && res.ready && !bypass && any_free;
  assign release_en = release_i && buf_hit;

  assign hit_o      = buf_hit || bypass;
  assign hit_data_o = buf_hit ? entry_q[hit_idx].data : res.data;
  assign hit_we_o   = buf_hit ? entry_q[hit_idx].we   : res.we;
  assign hit_exc_o  = buf_hit ? entry_q[hit_idx].exc  : res.exc;

  always_comb begin
    occupancy_d = occupancy_q + OCC_W'(alloc) - OCC_W'(release_en);
    if (rst || flush_i) occupancy_d = '0;
  end

  // Only valid bits are cleared; payload fields keep stale contents.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i].valid <= 1'b0;
    end else begin
      if (release_en) entry_q[hit_idx].valid <= 1'b0;
      if (alloc) begin
        entry_q[alloc_idx] <= '{valid: 1'b1, id: res.id, data: res.data,
                                we: res.we, exc: res.exc};
      end
    end
    occupancy_q <= occupancy_d;
  end

  assign occupancy_o = occupancy_q;

  // The coprocessor never re-sends a result whose ID is already buffered.
  a_no_dup_match: assert property (@(posedge clk) disable iff (rst)
    !(buf_hit && res.valid && id_match));

endmodule

// File: rtl/cv32e40x_wb_stage_rb.sv
// Write-back stage: LSU and ALU/MUL/DIV/CSR write-back plus an eXtension result
// buffer that lets coprocessor results arrive before their instruction reaches WB.
//   clk, rst                 : clock, synchronous active-high reset
//   ex_wb_pipe_i, ctrl_fsm_i : EX/WB pipe and controller kill/halt
//   lsu_*                    : LSU load data, MPU status and handshake
//   xif_result, xif_flush_i  : coprocessor result channel and buffer flush
//   rf_*_wb_o                : register file write port
//   data_stall_o, wb_*_o     : stall and WB handshake to the controller
//   rb_occupancy_o           : buffered result count
module cv32e40x_wb_stage_rb
  import cv32e40x_pkg::*;
#(
  parameter int X_RESULT_DEPTH = 2,
  parameter int X_ID_WIDTH     = 4,
  parameter int X_DATA_WIDTH   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  ex_wb_pipe_t                           ex_wb_pipe_i,
  input  ctrl_fsm_t                             ctrl_fsm_i,
  input  logic [31:0]                           lsu_rdata_i,
  input  mpu_status_e                           lsu_mpu_status_i,
  input  logic                                  lsu_valid_i,
  output logic                                  lsu_ready_o,
  output logic                                  lsu_valid_o,
  input  logic                                  lsu_ready_i,
  cv32e40x_wb_stage_rb_if.slave                 xif_result,
  input  logic                                  xif_flush_i,
  output logic                                  rf_we_wb_o,
  output logic [4:0]                            rf_waddr_wb_o,
  output logic [31:0]                           rf_wdata_wb_o,
  output logic                                  data_stall_o,
  output logic                                  wb_ready_o,
  output logic                                  wb_valid_o,
  output logic [$clog2(X_RESULT_DEPTH+1)-1:0]   rb_occupancy_o
);
  logic                    instr_valid;
  logic                    lsu_en;
  logic                    xif_en;
  logic                    lsu_exc;
  logic                    lookup_en;
  logic [X_ID_WIDTH-1:0]   wb_xif_id;
  logic                    hit;
  logic [X_DATA_WIDTH-1:0] hit_data;
  logic                    hit_we;
  logic                    hit_exc;
  logic                    xif_waiting;
  logic                    release_entry;

  assign instr_valid = ex_wb_pipe_i.instr_valid && !ctrl_fsm_i.kill_wb && !ctrl_fsm_i.halt_wb;
  assign lsu_en      = ex_wb_pipe_i.lsu_en;
  assign xif_en      = ex_wb_pipe_i.xif_en;
  assign lsu_exc     = lsu_en && (lsu_mpu_status_i != MPU_OK);
  // Lookup uses the unqualified valid so a killed instruction can still drop its entry.
  assign lookup_en   = ex_wb_pipe_i.instr_valid && xif_en;
  assign wb_xif_id   = ex_wb_pipe_i.xif_id;

  assign release_entry = xif_en && (wb_valid_o || ctrl_fsm_i.kill_wb);

  cv32e40x_xif_result_buffer #(
    .DEPTH (X_RESULT_DEPTH)
  ) u_rb (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (xif_flush_i),
    .lookup_en_i (lookup_en),
    .lookup_id_i (wb_xif_id),
    .release_i   (release_entry),
    .res         (xif_result),
    .hit_o       (hit),
    .hit_data_o  (hit_data),
    .hit_we_o    (hit_we),
    .hit_exc_o   (hit_exc),
    .occupancy_o (rb_occupancy_o)
  );

  assign xif_waiting = lookup_en && !hit;

  assign lsu_ready_o = 1'b1;
  assign lsu_valid_o = ex_wb_pipe_i.instr_valid && lsu_en;

  assign rf_we_wb_o = ex_wb_pipe_i.rf_we && instr_valid && !lsu_exc && !xif_waiting &&
                      !(xif_en && hit_exc) && !(xif_en && !hit_we);
  assign rf_waddr_wb_o = ex_wb_pipe_i.rf_waddr;
  assign rf_wdata_wb_o = lsu_en ? lsu_rdata_i : (xif_en ? hit_data : ex_wb_pipe_i.rf_wdata);

  assign wb_ready_o   = lsu_ready_i && !xif_waiting;
  assign wb_valid_o   = instr_valid && ((!lsu_en && !xif_waiting) ||
                                        (lsu_en && (lsu_valid_i || lsu_exc)));
  assign data_stall_o = instr_valid && ((lsu_en && !lsu_valid_i && !wb_valid_o) || xif_waiting);

endmodule

// File: tb/tb_cv32e40x_wb_stage_rb.sv
module tb_cv32e40x_wb_stage_rb;
  import cv32e40x_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  ex_wb_pipe_t pipe;
  ctrl_fsm_t   ctrl;
  logic [31:0] lsu_rdata;
  mpu_status_e mpu;
  logic        lsu_valid_in;
  logic        lsu_ready_in;
  logic        flush;
  logic        lsu_ready_out, lsu_valid_out;
  logic        rf_we, data_stall, wb_ready, wb_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  occ;

  cv32e40x_wb_stage_rb_if #(.X_ID_WIDTH(4), .X_DATA_WIDTH(32)) xif_if ();

  cv32e40x_wb_stage_rb #(.X_RESULT_DEPTH(DEPTH), .X_ID_WIDTH(4), .X_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ex_wb_pipe_i(pipe), .ctrl_fsm_i(ctrl),
    .lsu_rdata_i(lsu_rdata), .lsu_mpu_status_i(mpu), .lsu_valid_i(lsu_valid_in),
    .lsu_ready_o(lsu_ready_out), .lsu_valid_o(lsu_valid_out), .lsu_ready_i(lsu_ready_in),
    .xif_result(xif_if), .xif_flush_i(flush),
    .rf_we_wb_o(rf_we), .rf_waddr_wb_o(rf_waddr), .rf_wdata_wb_o(rf_wdata),
    .data_stall_o(data_stall), .wb_ready_o(wb_ready), .wb_valid_o(wb_valid),
    .rb_occupancy_o(occ)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered results indexed by ID plus a count.
  bit          m_have [16];
  logic [31:0] m_data [16];
  bit          m_we   [16];
  bit          m_exc  [16];
  int          m_count = 0;

  bit          e_ready, e_bufhit, e_byp, e_hit, e_wb_valid, e_wb_ready, e_stall;
  bit          e_rf_we, e_lsu_valid, e_wdata_known;
  logic [31:0] e_wdata;

  function automatic void model_eval();
    bit iv, lexc, look, idm, waiting, h_we, h_exc;
    logic [31:0] h_data;
    iv       = pipe.instr_valid && !ctrl.kill_wb && !ctrl.halt_wb;
    lexc     = pipe.lsu_en && (mpu != MPU_OK);
    look     = pipe.instr_valid && pipe.xif_en;
    e_bufhit = look && m_have[pipe.xif_id];
    idm      = look && (xif_if.id == pipe.xif_id);
    e_ready  = !rst && ((m_count < DEPTH) || idm);
    e_byp    = xif_if.valid && e_ready && idm && !e_bufhit;
    e_hit    = e_bufhit || e_byp;
    h_data   = e_bufhit ? m_data[pipe.xif_id] : xif_if.data;
    h_we     = e_bufhit ? m_we[pipe.xif_id]   : xif_if.we;
    h_exc    = e_bufhit ? m_exc[pipe.xif_id]  : xif_if.exc;
    waiting  = look && !e_hit;
    e_wb_valid = iv && ((!pipe.lsu_en && !waiting) || (pipe.lsu_en && (lsu_valid_in || lexc)));
    e_wb_ready = lsu_ready_in && !waiting;
    e_stall    = iv && ((pipe.lsu_en && !lsu_valid_in && !e_wb_valid) || waiting);
    e_rf_we    = pipe.rf_we && iv && !lexc && !waiting && !(pipe.xif_en && h_exc) &&
                 !(pipe.xif_en && !h_we);
    e_wdata    = pipe.lsu_en ? lsu_rdata : (pipe.xif_en ? h_data : pipe.rf_wdata);
    e_wdata_known = pipe.lsu_en || !pipe.xif_en || e_hit;
    e_lsu_valid   = pipe.lsu_en && pipe.instr_valid;
  endfunction

  function automatic void model_commit();
    if (rst || flush) begin
      foreach (m_have[i]) m_have[i] = 1'b0;
      m_count = 0;
    end else begin
      if ((e_wb_valid || ctrl.kill_wb) && pipe.xif_en && e_bufhit) begin
        m_have[pipe.xif_id] = 1'b0;
        m_count--;
      end
      if (xif_if.valid && e_ready && !e_byp) begin
        m_have[xif_if.id] = 1'b1;
        m_data[xif_if.id] = xif_if.data;
        m_we[xif_if.id]   = xif_if.we;
        m_exc[xif_if.id]  = xif_if.exc;
        m_count++;
      end
    end
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_eval();
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pipe = '0; ctrl = '0; lsu_rdata = 32'h0; mpu = MPU_OK;
    lsu_valid_in = 1'b0; lsu_ready_in = 1'b1; flush = 1'b0;
    xif_if.valid = 1'b0; xif_if.id = 4'h0; xif_if.data = 32'h0;
    xif_if.we = 1'b0; xif_if.exc = 1'b0;
  endtask

  task automatic offer(input int id, input logic [31:0] data, input bit we, input bit exc);
    xif_if.valid = 1'b1; xif_if.id = 4'(id); xif_if.data = data;
    xif_if.we = we; xif_if.exc = exc;
  endtask

  task automatic wb_xif(input int id, input int waddr, input bit we);
    pipe = '0;
    pipe.instr_valid = 1'b1; pipe.xif_en = 1'b1; pipe.xif_id = 4'(id);
    pipe.rf_waddr = 5'(waddr); pipe.rf_we = we;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1;
    settle();
    checks++; if (xif_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready_during: got %0b expected 0", xif_if.ready); end
    advance(); advance(); settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    checks++; if (xif_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held: got %0b expected 0", xif_if.ready); end
    rst = 1'b0; settle();
    checks++; if (xif_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %0b expected 1", xif_if.ready); end
    $display("test_reset done");
  endtask

  task automatic test_buffered_hit();
    offer(3, 32'hA5, 1, 0); settle();
    checks++; if (xif_if.ready !== 1'b1) begin errors++; $display("FAIL buf_ready: got %0b expected 1", xif_if.ready); end
    advance(); xif_if.valid = 1'b0;
    repeat (3) advance();
    settle();
    checks++; if (occ !== 2'd1) begin errors++; $display("FAIL buf_occ1: got %0d expected 1", occ); end
    wb_xif(3, 7, 1); settle();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL buf_rf_we: got %0b expected 1", rf_we); end
    checks++; if (rf_wdata !== 32'hA5) begin errors++; $display("FAIL buf_wdata: got %0h expected a5", rf_wdata); end
    checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL buf_waddr: got %0d expected 7", rf_waddr); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL buf_wb_valid: got %0b expected 1", wb_valid); end
    advance(); pipe = '0; settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL buf_occ0: got %0d expected 0", occ); end
    $display("test_buffered_hit done");
  endtask

  task automatic test_bypass();
    wb_xif(5, 9, 1); settle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL byp_wait_valid: got %0b expected 0", wb_valid); end
    checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL byp_wait_stall: got %0b expected 1", data_stall); end
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL byp_wait_ready: got %0b expected 0", wb_ready); end
    advance();
    offer(5, 32'h1234_5678, 1, 0); settle();
    checks++; if (xif_if.ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %0b expected 1", xif_if.ready); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL byp_wb_valid: got %0b expected 1", wb_valid); end
    checks++; if (rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL byp_wdata: got %0h expected 12345678", rf_wdata); end
    checks++; if (data_stall !== 1'b0) begin errors++; $display("FAIL byp_stall: got %0b expected 0", data_stall); end
    advance(); pipe = '0; xif_if.valid = 1'b0; settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL byp_occ: got %0d expected 0", occ); end
    $display("test_bypass done");
  endtask

  task automatic test_full();
    offer(1, 32'h11, 1, 0); advance();
    offer(2, 32'h22, 1, 0); advance();
    offer(7, 32'h77, 1, 0); settle();
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL full_occ2: got %0d expected 2", occ); end
    checks++; if (xif_if.ready !== 1'b0) begin errors++; $display("FAIL full_ready0: got %0b expected 0", xif_if.ready); end
    advance();
    wb_xif(1, 3, 1); settle();
    checks++; if (xif_if.ready !== 1'b0) begin errors++; $display("FAIL full_ready_retire: got %0b expected 0", xif_if.ready); end
    checks++; if (rf_wdata !== 32'h11) begin errors++; $display("FAIL full_wdata1: got %0h expected 11", rf_wdata); end
    advance(); pipe = '0; settle();
    checks++; if (occ !== 2'd1) begin errors++; $display("FAIL full_occ1: got %0d expected 1", occ); end
    checks++; if (xif_if.ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %0b expected 1", xif_if.ready); end
    advance(); xif_if.valid = 1'b0; settle();
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL full_occ_refill: got %0d expected 2", occ); end
    wb_xif(7, 4, 1); settle();
    checks++; if (rf_wdata !== 32'h77) begin errors++; $display("FAIL full_wdata7: got %0h expected 77", rf_wdata); end
    advance(); wb_xif(2, 5, 1); advance(); pipe = '0; settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", occ); end
    $display("test_full done");
  endtask

  task automatic test_exception();
    offer(4, 32'h44, 1, 1); advance(); xif_if.valid = 1'b0;
    wb_xif(4, 6, 1); settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL exc_rf_we: got %0b expected 0", rf_we); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL exc_wb_valid: got %0b expected 1", wb_valid); end
    advance(); pipe = '0; settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL exc_occ: got %0d expected 0", occ); end
    $display("test_exception done");
  endtask

  task automatic test_flush();
    offer(8, 32'h88, 1, 0); advance();
    offer(9, 32'h99, 1, 0); advance();
    offer(10, 32'hAA, 1, 0); flush = 1'b1; advance();
    flush = 1'b0; xif_if.valid = 1'b0; settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_full_occ: got %0d expected 0", occ); end
    offer(11, 32'hBB, 1, 0); advance();
    offer(12, 32'hCC, 1, 0); flush = 1'b1; settle();
    checks++; if (xif_if.ready !== 1'b1) begin errors++; $display("FAIL flush_alloc_ready: got %0b expected 1", xif_if.ready); end
    advance(); flush = 1'b0; xif_if.valid = 1'b0; settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_alloc_occ: got %0d expected 0", occ); end
    wb_xif(12, 2, 1); settle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_gone_valid: got %0b expected 0", wb_valid); end
    checks++; if (data_stall !== 1'b1) begin errors++; $display("FAIL flush_gone_stall: got %0b expected 1", data_stall); end
    pipe = '0; advance();
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    offer(13, 32'hD1, 1, 0); advance();
    offer(14, 32'hD2, 1, 0); advance();
    xif_if.valid = 1'b0; rst = 1'b1; settle();
    checks++; if (xif_if.ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %0b expected 0", xif_if.ready); end
    advance(); settle();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rstmid_occ: got %0d expected 0", occ); end
    rst = 1'b0; settle();
    checks++; if (xif_if.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %0b expected 1", xif_if.ready); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst  = ($urandom_range(0, 79) == 0);
      flush = ($urandom_range(0, 39) == 0);
      ctrl.kill_wb = ($urandom_range(0, 19) == 0);
      ctrl.halt_wb = ($urandom_range(0, 19) == 0);
      pipe.instr_valid = 1'($urandom_range(0, 1));
      pipe.xif_en   = ($urandom_range(0, 2) != 0);
      pipe.lsu_en   = !pipe.xif_en && ($urandom_range(0, 1) == 1);
      pipe.xif_id   = 4'($urandom_range(0, 7));
      pipe.rf_we    = ($urandom_range(0, 3) != 0);
      pipe.rf_waddr = 5'($urandom);
      pipe.rf_wdata = $urandom;
      lsu_rdata     = $urandom;
      lsu_valid_in  = 1'($urandom_range(0, 1));
      lsu_ready_in  = ($urandom_range(0, 3) != 0);
      mpu           = ($urandom_range(0, 5) == 0) ? MPU_RE_FAULT : MPU_OK;
      xif_if.id     = 4'($urandom_range(0, 7));
      xif_if.data   = $urandom;
      xif_if.we     = ($urandom_range(0, 3) != 0);
      xif_if.exc    = ($urandom_range(0, 5) == 0);
      // A result whose ID is already buffered is never re-sent.
      xif_if.valid  = ($urandom_range(0, 1) == 1) && !m_have[xif_if.id];
      settle();
      checks++; if (xif_if.ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d: got %0b expected %0b", c, xif_if.ready, e_ready); end
      checks++; if (wb_valid !== e_wb_valid) begin errors++; $display("FAIL rnd_wb_valid c=%0d: got %0b expected %0b", c, wb_valid, e_wb_valid); end
      checks++; if (wb_ready !== e_wb_ready) begin errors++; $display("FAIL rnd_wb_ready c=%0d: got %0b expected %0b", c, wb_ready, e_wb_ready); end
      checks++; if (data_stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d: got %0b expected %0b", c, data_stall, e_stall); end
      checks++; if (rf_we !== e_rf_we) begin errors++; $display("FAIL rnd_rf_we c=%0d: got %0b expected %0b", c, rf_we, e_rf_we); end
      checks++; if (rf_waddr !== pipe.rf_waddr) begin errors++; $display("FAIL rnd_waddr c=%0d: got %0d expected %0d", c, rf_waddr, pipe.rf_waddr); end
      checks++; if (lsu_valid_out !== e_lsu_valid) begin errors++; $display("FAIL rnd_lsu_valid c=%0d: got %0b expected %0b", c, lsu_valid_out, e_lsu_valid); end
      checks++; if (lsu_ready_out !== 1'b1) begin errors++; $display("FAIL rnd_lsu_ready c=%0d: got %0b expected 1", c, lsu_ready_out); end
      checks++; if (occ !== 2'(m_count)) begin errors++; $display("FAIL rnd_occ c=%0d: got %0d expected %0d", c, occ, m_count); end
      if (e_wdata_known) begin
        checks++; if (rf_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d: got %0h expected %0h", c, rf_wdata, e_wdata); end
      end
      advance();
    end
    $display("test_random done");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_buffered_hit();
    test_bypass();
    test_full();
    test_exception();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
